// File: rtl/pipe_stage_chain.sv
// Register pipeline of STAGES slots with per-slot valid bits, valid/ready on both sides,
// bubble collapse and a synchronous flush that wins over every transfer.
module pipe_stage_chain #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           STAGES     = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [DATA_WIDTH-1:0]         in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [$clog2(STAGES+1)-1:0]   count_o
);

  localparam int unsigned CW = $clog2(STAGES + 1);

  logic [STAGES-1:0]     valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [STAGES];
  logic [DATA_WIDTH-1:0] data_d [STAGES];
  logic [CW-1:0]         count_q, count_d;

  logic [STAGES:0]       ready;
  logic [STAGES-1:0]     xfer;
  logic                  push;
  logic                  pop;

  // ready(k) = !valid(k) | ready(k+1), walked back from the output side.
  always_comb begin : ready_chain
    logic rdy;
    rdy           = out_ready_i;
    ready         = '0;
    ready[STAGES] = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy      = ~valid_q[k] | rdy;
      ready[k] = rdy;
    end
  end

  assign in_ready_o = ready[0] & ~flush_i;
  assign push       = in_valid_i & in_ready_o;
  assign pop        = valid_q[STAGES-1] & out_ready_i;

  always_comb begin
    xfer    = '0;
    valid_d = valid_q;
    count_d = count_q;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
    end

    xfer[0] = push;
    for (int k = 1; k < STAGES; k++) begin
      xfer[k] = valid_q[k-1] & ready[k];
    end

    for (int k = 0; k < STAGES; k++) begin
      if (flush_i) begin
        valid_d[k] = 1'b0;
      end else if (xfer[k]) begin
        valid_d[k] = 1'b1;
      end else if (ready[k+1]) begin
        valid_d[k] = 1'b0;
      end
    end

    // Data registers only move on a real transfer; a flush leaves them untouched.
    if (xfer[0] && !flush_i) begin
      data_d[0] = in_data_i;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (xfer[k] && !flush_i) begin
        data_d[k] = data_q[k-1];
      end
    end

    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= RESET_DATA;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid_o = valid_q[STAGES-1];
  assign out_data_o  = data_q[STAGES-1];
  assign count_o     = count_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Drives a 3-stage/32-bit chain and a 1-stage/8-bit chain from shared stimulus and
// compares both against a queue-of-words model with explicit slot positions.
module tb_pipe_stage_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, flush, in_valid, out_ready;
  logic [31:0] in_data_a;
  logic [7:0]  in_data_b;
  logic        in_ready_a, out_valid_a;
  logic [31:0] out_data_a;
  logic [1:0]  count_a;
  logic        in_ready_b, out_valid_b;
  logic [7:0]  out_data_b;
  logic [0:0]  count_b;

  pipe_stage_chain #(.DATA_WIDTH(32), .STAGES(3), .RESET_DATA(32'h0)) u_a (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_data_i(in_data_a),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a),
    .count_o(count_a)
  );

  pipe_stage_chain #(.DATA_WIDTH(8), .STAGES(1), .RESET_DATA(8'h0)) u_b (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_data_i(in_data_b),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b),
    .count_o(count_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: in-flight words oldest first, each with its slot index; lo = output register content.
  logic [31:0] md [2][4];
  int          mp [2][4];
  int          mn [2];
  logic [31:0] lo [2];
  logic [31:0] wdata;
  bit          rand_data;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mn[m] = 0;
      lo[m] = 32'h0;
    end
  endtask

  task automatic model_step(input int m, input int s, input logic [31:0] d, input bit iv,
                            input bit ord, input bit fl, input bit obs_ov, input bit obs_ir,
                            input logic [31:0] obs_data, input int obs_cnt, output bit pushed);
    int          np [4];
    logic [31:0] nd [4];
    int          n2;
    bit          ov, ir;
    string       nm;
    nm = (m == 0) ? "a" : "b";
    ov = (mn[m] > 0) && (mp[m][0] == s - 1);
    for (int i = 0; i < mn[m]; i++) begin
      if (mp[m][i] == s - 1) begin
        np[i] = ord ? s : s - 1;
      end else if (i == 0) begin
        np[i] = mp[m][i] + 1;
      end else if (np[i-1] != mp[m][i] + 1) begin
        np[i] = mp[m][i] + 1;
      end else begin
        np[i] = mp[m][i];
      end
    end
    ir = !fl && ((mn[m] == 0) || (np[mn[m]-1] != 0));
    check_val({nm, "_out_valid"}, 32'(obs_ov), 32'(ov));
    check_val({nm, "_in_ready"}, 32'(obs_ir), 32'(ir));
    check_val({nm, "_count"}, obs_cnt, mn[m]);
    check_val({nm, "_out_data"}, obs_data, lo[m]);
    pushed = iv && ir;
    if (fl) begin
      mn[m] = 0;
    end else begin
      n2 = 0;
      for (int i = 0; i < mn[m]; i++) begin
        if (np[i] < s) begin
          if (np[i] == s - 1 && mp[m][i] != s - 1) lo[m] = md[m][i];
          nd[n2] = md[m][i];
          np[n2] = np[i];
          n2++;
        end
      end
      if (pushed) begin
        if (s == 1) lo[m] = d;
        nd[n2] = d;
        np[n2] = 0;
        n2++;
      end
      for (int i = 0; i < n2; i++) begin
        md[m][i] = nd[i];
        mp[m][i] = np[i];
      end
      mn[m] = n2;
    end
  endtask

  task automatic step(input bit iv, input bit ord, input bit fl);
    bit pa, pb;
    @(negedge clk);
    in_valid  = iv;
    in_data_a = wdata;
    in_data_b = wdata[7:0];
    out_ready = ord;
    flush     = fl;
    #1;
    model_step(0, 3, wdata, iv, ord, fl, out_valid_a, in_ready_a, out_data_a, int'(count_a), pa);
    model_step(1, 1, {24'h0, wdata[7:0]}, iv, ord, fl, out_valid_b, in_ready_b,
               {24'h0, out_data_b}, int'(count_b), pb);
    if (pa) wdata = rand_data ? $urandom : wdata + 32'd1;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data_a = '0; in_data_b = '0;
    rand_data = 1'b0;
    wdata = 32'hAAAA0000;
    model_reset();

    repeat (5) @(negedge clk);
    #1;
    check_val("rst_out_valid_a", 32'(out_valid_a), 32'h0);
    check_val("rst_count_a", 32'(count_a), 32'h0);
    check_val("rst_out_data_a", out_data_a, 32'h0);
    check_val("rst_in_ready_a", 32'(in_ready_a), 32'h1);
    check_val("rst_in_ready_b", 32'(in_ready_b), 32'h1);
    rstn = 1'b1;

    // Stream four words back to back
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 1) begin
        check_val("lat_b_valid", 32'(out_valid_b), 32'h1);
        check_val("lat_b_data", 32'(out_data_b), 32'h00);
      end
      if (i == 3) begin
        check_val("lat_a_valid", 32'(out_valid_a), 32'h1);
        check_val("lat_a_data", out_data_a, 32'hAAAA0000);
      end
    end
    repeat (4) step(1'b0, 1'b1, 1'b0);

    // Backpressure: four offered, three fit
    wdata = 32'hAAAA0000;
    repeat (4) step(1'b1, 1'b0, 1'b0);
    check_val("bp_count_a", 32'(count_a), 32'd3);
    check_val("bp_in_ready_a", 32'(in_ready_a), 32'h0);
    check_val("bp_hold_a", out_data_a, 32'hAAAA0000);
    step(1'b1, 1'b1, 1'b0);
    check_val("bp_pushpop_ready_a", 32'(in_ready_a), 32'h1);
    repeat (5) step(1'b0, 1'b1, 1'b0);

    // Bubbles with a stalled output
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    check_val("bub_count_a", 32'(count_a), 32'd3);
    check_val("bub_valid_a", 32'(out_valid_a), 32'h1);
    repeat (4) step(1'b0, 1'b1, 1'b0);

    // Flush with two words inside
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check_val("fl_in_ready_a", 32'(in_ready_a), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    check_val("fl_count_a", 32'(count_a), 32'h0);
    check_val("fl_valid_a", 32'(out_valid_a), 32'h0);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);

    rand_data = 1'b1;
    wdata = $urandom;
    repeat (400) step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0);

    // Asynchronous reset between edges while full
    repeat (4) step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check_val("arst_valid_a", 32'(out_valid_a), 32'h0);
    check_val("arst_count_a", 32'(count_a), 32'h0);
    check_val("arst_valid_b", 32'(out_valid_b), 32'h0);
    check_val("arst_count_b", 32'(count_b), 32'h0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    repeat (100) step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
